fifo_seq_ctrl: RTL

- Store-then-forward sequencer for the byte FIFO (128 x 8).
- Per packet: programs the FIFO length, loads exactly that many bytes from an upstream valid/ready byte source, then drains them to a downstream valid/ready sink.
- Generates the FIFO's edge-sensitive strobes: writes on input_en rising edge; reads advance on output_en falling edge.
- Checks the FIFO's full and read_complete flags against its own byte count.

---
 rtl/fifo_ctrl_pkg.sv | 24 ++
 rtl/fifo_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the store-then-forward FIFO sequencer.
package fifo_ctrl_pkg;

    localparam int unsigned DEPTH_DEFAULT = 128;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned STATUS_W      = 3;

    // Sticky status bit positions
    localparam int unsigned STAT_BAD_LEN  = 0;
    localparam int unsigned STAT_FLAG_MIS = 1;
    localparam int unsigned STAT_TIMEOUT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        WR_HI,
        WR_LO,
        CHK_FULL,
        DRAIN_HI,
        DRAIN_LO,
        CHK_RC
    } state_e;

endpackage

// File: rtl/fifo_seq_ctrl.sv
// Per-packet sequencer: programs the byte FIFO length, fills it from an
// upstream valid/ready source, then drains it to a downstream sink, while
// producing the FIFO's edge-sensitive strobes and cross-checking its flags.
module fifo_seq_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH         = DEPTH_DEFAULT,
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BYTE_W-1:0]   start_len,
    input  logic                abort,
    input  logic                wr_valid,
    input  logic [BYTE_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic                rd_valid,
    output logic [BYTE_W-1:0]   rd_data,
    input  logic                rd_ready,
    output logic                fifo_length_input_en,
    output logic [BYTE_W-1:0]   fifo_length_in,
    output logic                fifo_input_en,
    output logic [BYTE_W-1:0]   fifo_data_in,
    output logic                fifo_output_en,
    input  logic [BYTE_W-1:0]   fifo_data_out,
    input  logic                fifo_full,
    input  logic                fifo_read_complete,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [STATUS_W-1:0] status
);

    // Stall counter keeps at least one bit so a disabled watchdog still elaborates
    localparam int unsigned STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    state_e              state, state_nxt;
    logic [BYTE_W-1:0]   len, len_nxt;
    logic [BYTE_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [STALL_W-1:0]  stall_cnt, stall_cnt_nxt;
    logic [STATUS_W-1:0] status_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic                len_ok;
    logic                last_byte;
    logic                stall_expired;

    assign len_ok        = (start_len != '0) && (32'(start_len) <= DEPTH);
    assign last_byte     = (byte_cnt + 8'd1) == len;
    assign stall_expired = (STALL_TIMEOUT != 0) && ((32'(stall_cnt) + 32'd1) >= STALL_TIMEOUT);

    // Handshake passthroughs follow the current phase with no extra latency
    assign wr_ready      = (state == WR_HI);
    assign fifo_input_en = (state == WR_HI) && wr_valid;
    assign fifo_data_in  = wr_data;
    assign rd_valid      = (state == DRAIN_HI);
    assign rd_data       = fifo_data_out;

    // Next-state, counter and status decisions; abort overrides every transition
    always_comb begin
        state_nxt     = state;
        len_nxt       = len;
        byte_cnt_nxt  = byte_cnt;
        stall_cnt_nxt = '0;
        status_nxt    = status;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        if ((state != IDLE) && abort) begin
            state_nxt                = IDLE;
            err_nxt                  = 1'b1;
            status_nxt[STAT_TIMEOUT] = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_nxt    = start_len;
                            status_nxt = '0;
                            state_nxt  = CFG;
                        end else begin
                            err_nxt                  = 1'b1;
                            status_nxt[STAT_BAD_LEN] = 1'b1;
                        end
                    end
                end
                CFG: begin
                    byte_cnt_nxt = '0;
                    state_nxt    = WR_HI;
                end
                WR_HI: begin
                    if (wr_valid) begin
                        state_nxt = WR_LO;
                    end
                end
                WR_LO: begin
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    state_nxt    = last_byte ? CHK_FULL : WR_HI;
                end
                CHK_FULL: begin
                    if (!fifo_full) begin
                        err_nxt                   = 1'b1;
                        status_nxt[STAT_FLAG_MIS] = 1'b1;
                    end
                    byte_cnt_nxt = '0;
                    state_nxt    = DRAIN_HI;
                end
                DRAIN_HI: begin
                    if (rd_ready) begin
                        state_nxt = DRAIN_LO;
                    end else if (stall_expired) begin
                        state_nxt                = IDLE;
                        err_nxt                  = 1'b1;
                        status_nxt[STAT_TIMEOUT] = 1'b1;
                    end else begin
                        stall_cnt_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_W'(1);
                    end
                end
                DRAIN_LO: begin
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    state_nxt    = last_byte ? CHK_RC : DRAIN_HI;
                end
                CHK_RC: begin
                    if (!fifo_read_complete) begin
                        err_nxt                   = 1'b1;
                        status_nxt[STAT_FLAG_MIS] = 1'b1;
                    end
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; strobes decode the upcoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            len                  <= '0;
            byte_cnt             <= '0;
            stall_cnt            <= '0;
            fifo_length_input_en <= 1'b0;
            fifo_length_in       <= '0;
            fifo_output_en       <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            status               <= '0;
        end else begin
            state                <= state_nxt;
            len                  <= len_nxt;
            byte_cnt             <= byte_cnt_nxt;
            stall_cnt            <= stall_cnt_nxt;
            fifo_length_input_en <= (state_nxt == CFG);
            fifo_length_in       <= len_nxt;
            fifo_output_en       <= (state_nxt == DRAIN_HI);
            busy                 <= (state_nxt != IDLE);
            done                 <= done_nxt;
            err                  <= err_nxt;
            status               <= status_nxt;
        end
    end

endmodule
